c1541_track_ctrl: RTL and testbench

//  Owns the single-port track buffer RAM shared by the GCR bit engine and the SD image loader.
//  - Sequences track changes: settle after head step, write back a dirty track, load the new track.
//  - Drives ram_ready to the GCR engine: GCR owns the RAM only while ram_ready=1.
//  - Loader owns the RAM at all other times.

---
 rtl/c1541_track_ctrl_if.sv | 24 ++
 rtl/c1541_track_ctrl.sv | 179 +++++++++++++++++
 tb/tb_c1541_track_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c1541_track_ctrl_if.sv
// Loader-side handshake and buffer port of the c1541 track controller.
// The controller uses the master modport (it issues track requests) and the SD image loader uses the slave modport.
interface c1541_track_ctrl_if #(
  parameter int ADDR_W = 13
);
  logic [6:0]        sd_track;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic [ADDR_W-1:0] sd_buff_addr;
  logic              sd_buff_we;
  logic [7:0]        sd_buff_dout;
  logic [7:0]        sd_buff_din;

  modport master (
    output sd_track, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_we, sd_buff_dout
  );

  modport slave (
    input  sd_track, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_we, sd_buff_dout
  );
endinterface

// File: rtl/c1541_track_ctrl.sv
// Track buffer owner: settles after head steps, writes back dirty tracks, loads new ones.
// Optional C1541_FLUSH_ON_MTR_OFF_EN: write back a dirty track when the spindle motor stops.
module c1541_track_ctrl #(
  parameter int SETTLE_CYCLES = 96000,
  parameter int ADDR_W        = 13
) (
  input  logic              clk32,
  input  logic              reset_n,
  input  logic [6:0]        half_track,
  input  logic              mtr,
  input  logic              img_mounted,
  input  logic [ADDR_W-1:0] gcr_addr,
  input  logic              gcr_we,
  input  logic [7:0]        gcr_di,
  output logic [7:0]        gcr_do,
  output logic              ram_ready,
  c1541_track_ctrl_if.master sd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_di,
  input  logic [7:0]        mem_do
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_LOAD   = 2'd2;
  localparam logic [1:0] ST_READY  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       ht_q;
  logic             dirty;
  logic             valid;
  logic             mount_pend;
  logic             ack_q;
  logic             change;
  logic             ack_fall;

  assign change   = (half_track != ht_q);
  assign ack_fall = ack_q & ~sd.sd_ack;

  always_comb begin
    mem_addr = ram_ready ? gcr_addr : sd.sd_buff_addr;
    mem_we   = ram_ready ? gcr_we   : sd.sd_buff_we;
    mem_di   = ram_ready ? gcr_di   : sd.sd_buff_dout;
  end

  assign gcr_do         = mem_do;
  assign sd.sd_buff_din = mem_do;

`ifdef C1541_FLUSH_ON_MTR_OFF_EN
  logic mtr_q;
  logic mtr_flush;
`else
  logic unused_mtr;
  assign unused_mtr = mtr;
`endif

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_SETTLE;
      cnt         <= '0;
      ht_q        <= '0;
      dirty       <= 1'b0;
      valid       <= 1'b0;
      mount_pend  <= 1'b0;
      ack_q       <= 1'b0;
      ram_ready   <= 1'b0;
      sd.sd_rd    <= 1'b0;
      sd.sd_wr    <= 1'b0;
      sd.sd_track <= '0;
`ifdef C1541_FLUSH_ON_MTR_OFF_EN
      mtr_q       <= 1'b0;
      mtr_flush   <= 1'b0;
`endif
    end else begin
      ht_q  <= half_track;
      ack_q <= sd.sd_ack;
`ifdef C1541_FLUSH_ON_MTR_OFF_EN
      mtr_q <= mtr;
`endif
      case (state)
        ST_SETTLE: begin
          mount_pend <= 1'b0;
          if (change || img_mounted) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            // A write-back keeps sd_track, which still names the buffered track.
            if (dirty) begin
              state    <= ST_FLUSH;
              sd.sd_wr <= 1'b1;
            end else begin
              state       <= ST_LOAD;
              sd.sd_rd    <= 1'b1;
              sd.sd_track <= half_track;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_FLUSH: begin
          if (img_mounted) mount_pend <= 1'b1;
          if (sd.sd_ack) sd.sd_wr <= 1'b0;
          if (ack_fall && !sd.sd_wr) begin
            dirty <= 1'b0;
`ifdef C1541_FLUSH_ON_MTR_OFF_EN
            mtr_flush <= 1'b0;
`endif
            if (img_mounted || mount_pend) begin
              state <= ST_SETTLE;
`ifdef C1541_FLUSH_ON_MTR_OFF_EN
            end else if (mtr_flush) begin
              if (half_track == sd.sd_track) begin
                state     <= ST_READY;
                ram_ready <= 1'b1;
              end else begin
                state <= ST_SETTLE;
              end
`endif
            end else begin
              state       <= ST_LOAD;
              sd.sd_rd    <= 1'b1;
              sd.sd_track <= half_track;
            end
          end
        end

        ST_LOAD: begin
          if (img_mounted) mount_pend <= 1'b1;
          if (sd.sd_ack) sd.sd_rd <= 1'b0;
          if (ack_fall && !sd.sd_rd) begin
            // Data from a replaced image is never marked valid.
            if (img_mounted || mount_pend) begin
              state <= ST_SETTLE;
            end else begin
              valid <= 1'b1;
              if (half_track == sd.sd_track) begin
                state     <= ST_READY;
                ram_ready <= 1'b1;
              end else begin
                state <= ST_SETTLE;
              end
            end
          end
        end

        ST_READY: begin
          if (gcr_we) dirty <= 1'b1;
          if (change || img_mounted || !valid) begin
            state     <= ST_SETTLE;
            ram_ready <= 1'b0;
`ifdef C1541_FLUSH_ON_MTR_OFF_EN
          end else if (dirty && mtr_q && !mtr) begin
            state     <= ST_FLUSH;
            ram_ready <= 1'b0;
            sd.sd_wr  <= 1'b1;
            mtr_flush <= 1'b1;
`endif
          end
        end

        default: begin
          state     <= ST_SETTLE;
          ram_ready <= 1'b0;
        end
      endcase

      // A new image discards dirty/valid regardless of what the state update wanted.
      if (img_mounted) begin
        dirty <= 1'b0;
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_c1541_track_ctrl.sv
// Directed self-checking bench for c1541_track_ctrl with a shortened settle time.
module tb_c1541_track_ctrl;
  localparam int SETTLE = 200;
  localparam int AW     = 13;

  logic          clk32 = 1'b0;
  logic          reset_n = 1'b0;
  logic [6:0]    half_track;
  logic          mtr;
  logic          img_mounted;
  logic [AW-1:0] gcr_addr;
  logic          gcr_we;
  logic [7:0]    gcr_di;
  logic [7:0]    gcr_do;
  logic          ram_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_di;
  logic [7:0]    mem_do;

  always #5 clk32 = ~clk32;

  c1541_track_ctrl_if #(.ADDR_W(AW)) sd ();

  c1541_track_ctrl #(.SETTLE_CYCLES(SETTLE), .ADDR_W(AW)) dut (
    .clk32      (clk32),
    .reset_n    (reset_n),
    .half_track (half_track),
    .mtr        (mtr),
    .img_mounted(img_mounted),
    .gcr_addr   (gcr_addr),
    .gcr_we     (gcr_we),
    .gcr_di     (gcr_di),
    .gcr_do     (gcr_do),
    .ram_ready  (ram_ready),
    .sd         (sd),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_di     (mem_di),
    .mem_do     (mem_do)
  );

  logic [7:0] ram [0:8191];
  always @(posedge clk32) begin
    if (mem_we) ram[mem_addr] <= mem_di;
    mem_do <= ram[mem_addr];
  end

  int   rd_rises = 0, wr_rises = 0, both_hi = 0;
  logic rd_d = 1'b0, wr_d = 1'b0;
  always @(posedge clk32) begin
    if (sd.sd_rd && !rd_d) rd_rises++;
    if (sd.sd_wr && !wr_d) wr_rises++;
    if (sd.sd_rd && sd.sd_wr) both_hi++;
    rd_d = sd.sd_rd;
    wr_d = sd.sd_wr;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int a, input logic [7:0] s);
    return 8'(a * 7) ^ s;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk32);
  endtask

  task automatic wait_req(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 2 * SETTLE + 40 && !got; i++) begin
      @(negedge clk32);
      got = sd.sd_rd | sd.sd_wr;
    end
    chk({name, "_req_timeout"}, 32'(got), 32'd1);
  endtask

  task automatic wait_ready(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk32);
      got = ram_ready;
    end
    chk({name, "_ready_timeout"}, 32'(got), 32'd1);
  endtask

  task automatic xfer(input int n, input bit load, input logic [7:0] seed,
                      input int step_at, input logic [6:0] step_to, input int mount_at);
    @(negedge clk32);
    sd.sd_ack = 1'b1;
    for (int i = 0; i < n; i++) begin
      sd.sd_buff_addr = AW'(i);
      sd.sd_buff_we   = load;
      sd.sd_buff_dout = pat(i, seed);
      if (i == step_at) half_track = step_to;
      img_mounted = (i == mount_at);
      @(negedge clk32);
    end
    sd.sd_buff_we = 1'b0;
    img_mounted   = 1'b0;
    sd.sd_ack     = 1'b0;
  endtask

  task automatic gcr_read(input string name, input logic [AW-1:0] a, input logic [7:0] exp);
    gcr_addr = a;
    @(negedge clk32);
    chk({name, "_gcr_do"}, 32'(gcr_do), 32'(exp));
    chk({name, "_buff_din"}, 32'(sd.sd_buff_din), 32'(exp));
  endtask

  task automatic not_ready_for(input string name, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      @(negedge clk32);
      seen |= ram_ready;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  typedef struct {
    bit            in_ready;
    logic [AW-1:0] ga;
    logic          gw;
    logic [7:0]    gd;
    logic [AW-1:0] sa;
    logic          sw;
    logic [7:0]    sdo;
    logic [AW-1:0] ea;
    logic          ew;
    logic [7:0]    ed;
  } vec_t;
  vec_t vecs [5];

  task automatic apply_vecs(input bit phase);
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].in_ready == phase) begin
        @(negedge clk32);
        gcr_addr = vecs[i].ga; gcr_we = vecs[i].gw; gcr_di = vecs[i].gd;
        sd.sd_buff_addr = vecs[i].sa; sd.sd_buff_we = vecs[i].sw; sd.sd_buff_dout = vecs[i].sdo;
        #1;
        chk($sformatf("mux%0d_addr", i), 32'(mem_addr), 32'(vecs[i].ea));
        chk($sformatf("mux%0d_we", i),   32'(mem_we),   32'(vecs[i].ew));
        chk($sformatf("mux%0d_di", i),   32'(mem_di),   32'(vecs[i].ed));
      end
    end
    @(negedge clk32);
    gcr_addr = '0; gcr_we = 1'b0; gcr_di = '0;
    sd.sd_buff_addr = '0; sd.sd_buff_we = 1'b0; sd.sd_buff_dout = '0;
  endtask

  int rbase, wbase;

  initial begin
    half_track = 7'd36; mtr = 1'b1; img_mounted = 1'b0;
    gcr_addr = '0; gcr_we = 1'b0; gcr_di = '0;
    sd.sd_ack = 1'b0; sd.sd_buff_addr = '0; sd.sd_buff_we = 1'b0; sd.sd_buff_dout = '0;

    vecs[0] = '{1'b0, 13'h0011, 1'b1, 8'h11, 13'h1ABC, 1'b0, 8'h5A, 13'h1ABC, 1'b0, 8'h5A};
    vecs[1] = '{1'b0, 13'h0022, 1'b0, 8'h22, 13'h0003, 1'b1, 8'hC3, 13'h0003, 1'b1, 8'hC3};
    vecs[2] = '{1'b0, 13'h1FFF, 1'b1, 8'hFF, 13'h0000, 1'b0, 8'h00, 13'h0000, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 13'h0123, 1'b0, 8'h77, 13'h1555, 1'b1, 8'h99, 13'h0123, 1'b0, 8'h77};
    vecs[4] = '{1'b1, 13'h1FFF, 1'b0, 8'h00, 13'h0001, 1'b0, 8'hEE, 13'h1FFF, 1'b0, 8'h00};

    cyc(3);
    chk("rst_ram_ready", 32'(ram_ready), 32'd0);
    chk("rst_sd_rd", 32'(sd.sd_rd), 32'd0);
    chk("rst_sd_wr", 32'(sd.sd_wr), 32'd0);
    chk("rst_sd_track", 32'(sd.sd_track), 32'd0);
    @(negedge clk32);
    reset_n = 1'b1;

    // 1: initial load; GCR writes while the loader owns the RAM must not mark the track dirty
    apply_vecs(1'b0);
    cyc(SETTLE - 10);
    chk("t1_no_early_rd", 32'(sd.sd_rd), 32'd0);
    wait_req("t1");
    chk("t1_sd_rd", 32'(sd.sd_rd), 32'd1);
    chk("t1_sd_wr", 32'(sd.sd_wr), 32'd0);
    chk("t1_sd_track", 32'(sd.sd_track), 32'd36);
    xfer(8192, 1'b1, 8'h3C, -1, 7'd0, -1);
    wait_ready("t1");
    gcr_read("t1_a5", 13'd5, pat(5, 8'h3C));
    gcr_read("t1_a3", 13'd3, pat(3, 8'h3C));
    gcr_read("t1_last", 13'h1FFF, pat(8191, 8'h3C));
    apply_vecs(1'b1);

    // 2: clean track change
    @(negedge clk32) half_track = 7'd38;
    @(negedge clk32);
    chk("t2_ready_drop", 32'(ram_ready), 32'd0);
    wait_req("t2");
    chk("t2_sd_rd", 32'(sd.sd_rd), 32'd1);
    chk("t2_sd_track", 32'(sd.sd_track), 32'd38);
    chk("t2_no_wr", 32'(wr_rises), 32'd0);
    xfer(64, 1'b1, 8'h55, -1, 7'd0, -1);
    wait_ready("t2");
    gcr_read("t2_a10", 13'd10, pat(10, 8'h55));

    // 3: write and step in the same cycle -> write lands, old track flushed
    @(negedge clk32);
    gcr_addr = 13'd10; gcr_di = 8'hA5; gcr_we = 1'b1; half_track = 7'd36;
    @(negedge clk32);
    gcr_we = 1'b0;
    chk("t3_ready_drop", 32'(ram_ready), 32'd0);
    chk("t3_write_landed", 32'(ram[10]), 32'hA5);
    wait_req("t3");
    chk("t3_sd_wr", 32'(sd.sd_wr), 32'd1);
    chk("t3_sd_rd", 32'(sd.sd_rd), 32'd0);
    chk("t3_wr_track", 32'(sd.sd_track), 32'd38);
    sd.sd_ack = 1'b1; sd.sd_buff_addr = 13'd10;
    @(negedge clk32);
    chk("t3_wr_drop", 32'(sd.sd_wr), 32'd0);
    chk("t3_flush_data", 32'(sd.sd_buff_din), 32'hA5);
    cyc(5);
    sd.sd_ack = 1'b0;
    wait_req("t3b");
    chk("t3_rd_after_flush", 32'(sd.sd_rd), 32'd1);
    chk("t3_rd_track", 32'(sd.sd_track), 32'd36);
    xfer(64, 1'b1, 8'h66, -1, 7'd0, -1);
    wait_ready("t3");
    gcr_read("t3_reload", 13'd10, pat(10, 8'h66));

    // 4: rapid steps collapse into one load
    rbase = rd_rises; wbase = wr_rises;
    @(negedge clk32) half_track = 7'd37;
    cyc(50);
    half_track = 7'd38;
    cyc(50);
    chk("t4_still_settling", 32'(sd.sd_rd), 32'd0);
    wait_req("t4");
    chk("t4_sd_track", 32'(sd.sd_track), 32'd38);
    xfer(64, 1'b1, 8'h77, -1, 7'd0, -1);
    wait_ready("t4");
    chk("t4_one_load", 32'(rd_rises - rbase), 32'd1);
    chk("t4_no_flush", 32'(wr_rises - wbase), 32'd0);

    // 5: step during load -> load completes, resettle, reload
    @(negedge clk32) half_track = 7'd39;
    wait_req("t5");
    chk("t5_sd_track", 32'(sd.sd_track), 32'd39);
    xfer(64, 1'b1, 8'h88, 20, 7'd40, -1);
    not_ready_for("t5_stays_not_ready", 5);
    wait_req("t5b");
    chk("t5_sd_rd", 32'(sd.sd_rd), 32'd1);
    chk("t5_sd_track2", 32'(sd.sd_track), 32'd40);
    xfer(64, 1'b1, 8'h99, -1, 7'd0, -1);
    wait_ready("t5");

    // 6: dirty + new image -> no write-back; mount during load defers
    wbase = wr_rises;
    @(negedge clk32);
    gcr_addr = 13'd20; gcr_di = 8'h05; gcr_we = 1'b1;
    @(negedge clk32);
    gcr_we = 1'b0; img_mounted = 1'b1;
    @(negedge clk32);
    img_mounted = 1'b0;
    chk("t6_ready_drop", 32'(ram_ready), 32'd0);
    wait_req("t6");
    chk("t6_sd_rd", 32'(sd.sd_rd), 32'd1);
    chk("t6_sd_wr", 32'(sd.sd_wr), 32'd0);
    xfer(64, 1'b1, 8'h11, -1, 7'd0, 10);
    not_ready_for("t6_mount_pending", 5);
    wait_req("t6b");
    chk("t6_reload_rd", 32'(sd.sd_rd), 32'd1);
    chk("t6_reload_track", 32'(sd.sd_track), 32'd40);
    xfer(64, 1'b1, 8'h22, -1, 7'd0, -1);
    wait_ready("t6");
    chk("t6_no_flush", 32'(wr_rises - wbase), 32'd0);

`ifdef C1541_FLUSH_ON_MTR_OFF_EN
    rbase = rd_rises;
    @(negedge clk32);
    gcr_addr = 13'd30; gcr_di = 8'h30; gcr_we = 1'b1;
    @(negedge clk32);
    gcr_we = 1'b0; mtr = 1'b0;
    @(negedge clk32);
    chk("mtr_ready_drop", 32'(ram_ready), 32'd0);
    chk("mtr_sd_wr", 32'(sd.sd_wr), 32'd1);
    chk("mtr_track", 32'(sd.sd_track), 32'd40);
    xfer(16, 1'b0, 8'h00, -1, 7'd0, -1);
    wait_ready("mtr");
    chk("mtr_no_reload", 32'(rd_rises - rbase), 32'd0);
    mtr = 1'b1;
`else
    @(negedge clk32);
    gcr_addr = 13'd30; gcr_di = 8'h30; gcr_we = 1'b1;
    @(negedge clk32);
    gcr_we = 1'b0; mtr = 1'b0;
    cyc(10);
    chk("mtr_no_effect_ready", 32'(ram_ready), 32'd1);
    chk("mtr_no_effect_wr", 32'(sd.sd_wr), 32'd0);
    mtr = 1'b1;
`endif

    // reset with a request outstanding drops it asynchronously
    @(negedge clk32) half_track = 7'd41;
    wait_req("rst_mid");
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_rd", 32'(sd.sd_rd), 32'd0);
    chk("rst_mid_wr", 32'(sd.sd_wr), 32'd0);
    chk("rst_mid_ready", 32'(ram_ready), 32'd0);
    chk("rd_wr_exclusive", 32'(both_hi), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
